// File: rtl/cond_pkg.sv
// Shared definitions for the condition unit: ARM condition codes and NZCV bit positions.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic f_n, f_z, f_c, f_v;

    assign f_n = flags[FLAG_N];
    assign f_z = flags[FLAG_Z];
    assign f_c = flags[FLAG_C];
    assign f_v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = f_z;
            COND_NE: cond_ex = ~f_z;
            COND_CS: cond_ex = f_c;
            COND_CC: cond_ex = ~f_c;
            COND_MI: cond_ex = f_n;
            COND_PL: cond_ex = ~f_n;
            COND_VS: cond_ex = f_v;
            COND_VC: cond_ex = ~f_v;
            COND_HI: cond_ex = f_c & ~f_z;
            COND_LS: cond_ex = ~f_c | f_z;
            COND_GE: cond_ex = (f_n == f_v);
            COND_LT: cond_ex = (f_n != f_v);
            COND_GT: cond_ex = ~f_z & (f_n == f_v);
            COND_LE: cond_ex = f_z | (f_n != f_v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: holds NZCV, evaluates the instruction's condition, and gates
// the decoder's write/branch strobes so failed instructions have no effect.
module cond_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    input  logic       v,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       cond_ex,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic [3:0] flags_q
);

    logic [3:0] flags_d;
    logic       wr_nz;
    logic       wr_cv;

    // Condition is judged on the stored flags only, never the live ALU outputs.
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign wr_nz = flag_w[1] & cond_ex;
    assign wr_cv = flag_w[0] & cond_ex;

    // Unselected halves hold, so X on the ALU flags cannot leak in.
    always_comb begin
        flags_d = flags_q;
        if (wr_nz) begin
            flags_d[FLAG_N] = n;
            flags_d[FLAG_Z] = z;
        end
        if (wr_cv) begin
            flags_d[FLAG_C] = c;
            flags_d[FLAG_V] = v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= FLAG_RESET;
        else       flags_q <= flags_d;
    end

    assign pc_src    = pcs & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: driver pushes model expectations, monitor pops and compares.
module tb_cond_logic;

    localparam logic [3:0] FLAG_RESET = 4'b0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cond = 4'hE;
    logic       n = 1'b0, z = 1'b0, c = 1'b0, v = 1'b0;
    logic [1:0] flag_w = 2'b00;
    logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
    logic       cond_ex, pc_src, reg_write, mem_write;
    logic [3:0] flags_q;

    cond_logic #(.FLAG_RESET(FLAG_RESET)) dut (
        .clk(clk), .reset(reset), .cond(cond),
        .n(n), .z(z), .c(c), .v(v), .flag_w(flag_w),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write),
        .cond_ex(cond_ex), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic       ex;
        logic       pc;
        logic       rw;
        logic       mw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;
    logic [3:0] mflags;

    // Reference: ARM pseudocode style -- base test from cond[3:1], inverted by cond[0].
    function automatic bit cond_pass(input logic [3:0] cc, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        if (cc == 4'hF) return 1'b0;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic step(input string nm, input bit rst, input logic [3:0] cc,
                        input logic [1:0] fw, input logic [3:0] nzcv,
                        input bit p, input bit rw, input bit mw, input bit nw);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        reset = rst; cond = cc; flag_w = fw;
        n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
        ok      = cond_pass(cc, mflags);
        e.name  = nm;
        e.flags = mflags;
        e.ex    = ok;
        e.pc    = p && ok;
        e.rw    = rw && ok && !nw;
        e.mw    = mw && ok;
        exp_q.push_back(e);
        if (rst) mflags = FLAG_RESET;
        else if (ok) begin
            if (fw[1]) begin mflags[3] = nzcv[3]; mflags[2] = nzcv[2]; end
            if (fw[0]) begin mflags[1] = nzcv[1]; mflags[0] = nzcv[0]; end
        end
    endtask

    task automatic check1(input string nm, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, req);
        end
    endtask

    // Monitor: samples the DUT mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check1({e.name, ".flags_q"}, flags_q, e.flags);
                check1({e.name, ".cond_ex"}, {3'b0, cond_ex}, {3'b0, e.ex});
                check1({e.name, ".pc_src"}, {3'b0, pc_src}, {3'b0, e.pc});
                check1({e.name, ".reg_write"}, {3'b0, reg_write}, {3'b0, e.rw});
                check1({e.name, ".mem_write"}, {3'b0, mem_write}, {3'b0, e.mw});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $finish;
    end

    initial begin
        mflags = FLAG_RESET;
        repeat (2) @(posedge clk);
        // Directed sequence from the test plan.
        step("reset_ne",   1, 4'b0001, 2'b00, 4'b0000, 1, 0, 0, 0);
        step("ne_pcs",     0, 4'b0001, 2'b00, 4'b0000, 1, 0, 0, 0);
        step("al_wr11",    0, 4'b1110, 2'b11, 4'b0110, 0, 0, 0, 0);
        step("eq_after",   0, 4'b0000, 2'b00, 4'b0000, 1, 1, 1, 0);
        step("hi_after",   0, 4'b1000, 2'b00, 4'b0000, 1, 1, 1, 0);
        step("al_wr01",    0, 4'b1110, 2'b01, 4'b1001, 0, 0, 0, 0);
        step("ge_fail",    0, 4'b1010, 2'b11, 4'b1111, 1, 1, 1, 0);
        step("cmp",        0, 4'b1110, 2'b11, 4'b0011, 0, 1, 0, 1);
        step("after_cmp",  0, 4'b1111, 2'b11, 4'b1100, 1, 1, 1, 0);
        step("rst_vs_wr",  1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0);
        step("post_rst",   0, 4'b1110, 2'b00, 4'b0000, 1, 1, 1, 0);
        // Full sweep: load each flag value, then try every condition against it.
        for (int f = 0; f < 16; f++) begin
            step("sweep_load", 0, 4'b1110, 2'b11, 4'(f), 0, 0, 0, 0);
            for (int cc = 0; cc < 16; cc++)
                step("sweep", 0, 4'(cc), 2'b00, 4'(15 - f), 1, 1, 1, 0);
        end
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 31) == 0), 4'($urandom), 2'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        step("final", 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        done = 1;
        check1("scoreboard_drained", 4'(exp_q.size()), 4'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
